display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
Time-multiplexed scan controller that shares one seven-segment decode path (gray_decoder -> module_display) across N digit positions.
- Holds a double-buffered set of 4-bit binary digits.
- Steps through the digits at a programmable refresh rate, presenting one nibble at a time to the shared decoder and driving the matching active-low anode.
- Inserts dead time between digits to stop ghosting.
- Accepts new digit values through a valid/ready handshake and commits them only at frame boundaries, so no frame shows a mix of old and new digits.

Parameters:
N_DIGITS, 4, number of multiplexed digit positions (2..8)
SCAN_DIV, 27000, clock cycles per digit slot (>= DEAD_CYC+2)
DEAD_CYC, 64, cycles at the end of each slot with all anodes off (0 allowed)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load_valid  in  1  new digit set offered
load_ready  out  1  controller can accept a digit set
load_data  in  4*N_DIGITS  digit i at bits [4i+3:4i]; digit 0 is least significant
blank_lz  in  1  enable leading-zero blanking
digit_out  out  4  nibble sent to the shared decoder
digit_blank  out  1  current slot is blanked
anode_n  out  N_DIGITS  active-low digit enables, at most one low
frame_start  out  1  one-cycle pulse when slot 0 begins

Behaviour:
Reset:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- While rst_n=0: div_cnt=0, idx=0, active_buf=0, shadow_buf=0, state=IDLE, load_ready=1.
- Outputs during reset: anode_n=all ones, digit_out=0, digit_blank=0, frame_start=0.
- Reset asserted mid-frame or mid-handshake drops any pending shadow data.

Scan timing:
- div_cnt counts 0..SCAN_DIV-1 and wraps.
- On wrap, idx advances; idx wraps N_DIGITS-1 -> 0.
- A slot is "lit" when div_cnt < SCAN_DIV-DEAD_CYC; otherwise it is dead time.

Outputs:
- All outputs are registered, one cycle after the (div_cnt, idx) state they reflect.
- No combinational path from any input to any output.
- digit_out = active_buf nibble[idx], driven in both lit and dead cycles.
- anode_n[idx]=0 only when the slot is lit and the digit is not blanked; every other bit is 1.
- frame_start=1 in the output cycle that corresponds to div_cnt=0, idx=0.
- The first frame_start follows reset release by one cycle.

Leading-zero blanking:
- Digit i (i>0) is blanked when blank_lz=1 and active_buf digits N_DIGITS-1..i are all zero.
- Digit 0 is never blanked.
- digit_blank mirrors the blank decision for the current idx.
- blank_lz is sampled each cycle; no retiming.

Load handshake and state machine (states IDLE, PEND):
- IDLE: load_ready=1. A transfer occurs when load_valid & load_ready: shadow_buf <= load_data, and state -> PEND on the next cycle.
- PEND: load_ready=0; load_data is ignored.
- Commit cycle: div_cnt=SCAN_DIV-1 and idx=N_DIGITS-1. In PEND, active_buf <= shadow_buf, state -> IDLE, and load_ready=1 on the next cycle.
- Transfer on a commit cycle while in IDLE: shadow is captured and committed at the following frame boundary, not the current one.
- New data is first displayed in the slot-0 output cycle flagged by frame_start.
- load_valid may stay high; exactly one transfer per IDLE visit.

Decomposition:
Package display_pkg:
- nibble_t (logic [3:0])
- scan_state_t enum {IDLE, PEND}
- DEFAULT_N_DIGITS, DEFAULT_SCAN_DIV, DEFAULT_DEAD_CYC

Sub-module scan_timer:
- Holds div_cnt/idx and produces lit, slot_end and frame_end strobes.
- display_scan_ctrl owns the buffers, FSM, blanking and output registers.

Test Plan (N_DIGITS=4, SCAN_DIV=8, DEAD_CYC=2):
- Reset release, no load -> frame_start at cycle 1; anode_n sequence per slot: 1110 for 6 cycles, then 1111 for 2 cycles; pattern rotates 1101, 1011, 0111; period 32 cycles; digit_out=0.
- load_data=16'h4321 accepted at cycle 5 -> load_ready=0 from cycle 6; digit_out stays 0 until frame_start at cycle 33, then shows 1,2,3,4 per slot; load_ready=1 at cycle 33.
- blank_lz=1 with data 16'h0050 -> digits 3 and 2 keep anode_n all ones with digit_blank=1; digit 1 shows 5; digit 0 shows 0 and is lit.
- blank_lz=1 with data 16'h0000 -> only digit 0 is lit (shows 0); digits 1..3 blanked.
- Transfer on a commit cycle (16'hAAAA), then hold load_valid high with 16'hBBBB -> AAAA appears one frame later; BBBB is accepted the cycle after load_ready rises and appears one frame after that.
- rst_n pulsed low mid-slot while in PEND -> outputs go to reset values immediately; after release load_ready=1, the display shows 0, and the pending data is never displayed.

Source files
------------

// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and defaults for the multiplexed seven-segment scan controller.
package display_pkg;

    typedef logic [3:0] nibble_t;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } scan_state_t;

    localparam int DEFAULT_N_DIGITS = 4;
    localparam int DEFAULT_SCAN_DIV = 27000;
    localparam int DEFAULT_DEAD_CYC = 64;

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Digit-set load handshake between a host and the scan controller.
interface display_scan_ctrl_if #(
    parameter int N_DIGITS = 4
) ();

    logic                    load_valid;
    logic                    load_ready;
    logic [4*N_DIGITS-1:0]   load_data;

    modport master (
        output load_valid,
        output load_data,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_data,
        output load_ready
    );

endinterface

// File: rtl/display_scan_ctrl_timer.sv
// Slot divider and digit index counter with lit/slot/frame strobes.
module scan_timer
    import display_pkg::*;
#(
    parameter int N_DIGITS = DEFAULT_N_DIGITS,
    parameter int SCAN_DIV = DEFAULT_SCAN_DIV,
    parameter int DEAD_CYC = DEFAULT_DEAD_CYC
) (
    input  logic                        clk,
    input  logic                        rst_n,
    output logic [$clog2(N_DIGITS)-1:0] idx_o,
    output logic                        lit_o,
    output logic                        slot_end_o,
    output logic                        frame_end_o,
    output logic                        frame_begin_o
);

    localparam int DIV_W   = $clog2(SCAN_DIV);
    localparam int IDX_W   = $clog2(N_DIGITS);
    localparam int LIT_CYC = SCAN_DIV - DEAD_CYC;

    logic [DIV_W-1:0] div_q, div_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             slot_end;
    logic             last_idx;

    assign slot_end = (div_q == DIV_W'(SCAN_DIV - 1));
    assign last_idx = (idx_q == IDX_W'(N_DIGITS - 1));

    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (slot_end) begin
            div_d = '0;
            idx_d = last_idx ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
        end
    end

    // 32-bit compare so DEAD_CYC=0 still leaves every cycle lit
    assign lit_o         = (32'(div_q) < 32'(LIT_CYC));
    assign idx_o         = idx_q;
    assign slot_end_o    = slot_end;
    assign frame_end_o   = slot_end & last_idx;
    assign frame_begin_o = (div_q == '0) & (idx_q == '0);

endmodule

// File: rtl/display_scan_ctrl.sv
// Double-buffered digit scan controller driving one shared decode path.
module display_scan_ctrl
    import display_pkg::*;
#(
    parameter int N_DIGITS = DEFAULT_N_DIGITS,
    parameter int SCAN_DIV = DEFAULT_SCAN_DIV,
    parameter int DEAD_CYC = DEFAULT_DEAD_CYC
) (
    input  logic                clk,
    input  logic                rst_n,
    display_scan_ctrl_if.slave  load,
    input  logic                blank_lz,
    output nibble_t             digit_out,
    output logic                digit_blank,
    output logic [N_DIGITS-1:0] anode_n,
    output logic                frame_start
);

    localparam int IDX_W = $clog2(N_DIGITS);
    localparam int BUF_W = 4 * N_DIGITS;

    logic [IDX_W-1:0]    idx;
    logic                lit;
    logic                frame_end;
    logic                frame_begin;

    scan_state_t         state_q, state_d;
    logic [BUF_W-1:0]    active_q, active_d;
    logic [BUF_W-1:0]    shadow_q, shadow_d;

    nibble_t             digit_q;
    logic                blank_q;
    logic [N_DIGITS-1:0] anode_q, anode_d;
    logic                fs_q;

    logic [N_DIGITS-1:0] blank_v;
    logic                hi_zero;
    nibble_t             cur_nib;
    logic                cur_blank;

    scan_timer #(
        .N_DIGITS (N_DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .DEAD_CYC (DEAD_CYC)
    ) u_timer (
        .clk           (clk),
        .rst_n         (rst_n),
        .idx_o         (idx),
        .lit_o         (lit),
        .slot_end_o    (),
        .frame_end_o   (frame_end),
        .frame_begin_o (frame_begin)
    );

    assign load.load_ready = (state_q == IDLE);

    // Commit only on the frame boundary so a frame never mixes old and new digits
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        active_d = active_q;
        unique case (state_q)
            IDLE: begin
                if (load.load_valid) begin
                    shadow_d = load.load_data;
                    state_d  = PEND;
                end
            end
            PEND: begin
                if (frame_end) begin
                    active_d = shadow_q;
                    state_d  = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        blank_v = '0;
        hi_zero = 1'b1;
        for (int i = N_DIGITS - 1; i > 0; i--) begin
            hi_zero    = hi_zero & (active_q[4*i +: 4] == 4'h0);
            blank_v[i] = blank_lz & hi_zero;
        end
    end

    assign cur_nib   = active_q[{idx, 2'b00} +: 4];
    assign cur_blank = blank_v[idx];

    always_comb begin
        anode_d = '1;
        if (lit && !cur_blank) begin
            anode_d[idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= '0;
            blank_q <= 1'b0;
            anode_q <= '1;
            fs_q    <= 1'b0;
        end else begin
            digit_q <= cur_nib;
            blank_q <= cur_blank;
            anode_q <= anode_d;
            fs_q    <= frame_begin;
        end
    end

    assign digit_out   = digit_q;
    assign digit_blank = blank_q;
    assign anode_n     = anode_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Scoreboard bench: expected frames queued by stimulus, checked per cycle.
module tb_display_scan_ctrl;
    import display_pkg::*;

    localparam int N    = 4;
    localparam int DIV  = 8;
    localparam int DEAD = 2;
    localparam int FRM  = N * DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       blank_lz;
    nibble_t    digit_out;
    logic       digit_blank;
    logic [3:0] anode_n;
    logic       frame_start;

    always #5 clk = ~clk;

    display_scan_ctrl_if #(.N_DIGITS(N)) lif ();

    display_scan_ctrl #(
        .N_DIGITS (N),
        .SCAN_DIV (DIV),
        .DEAD_CYC (DEAD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (lif.slave),
        .blank_lz    (blank_lz),
        .digit_out   (digit_out),
        .digit_blank (digit_blank),
        .anode_n     (anode_n),
        .frame_start (frame_start)
    );

    typedef struct {
        logic [15:0] digits;
        logic [3:0]  blank;
    } frame_t;

    frame_t sb[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic frame_t mk(logic [15:0] d, logic [3:0] b);
        frame_t f;
        f.digits = d;
        f.blank  = b;
        return f;
    endfunction

    frame_t     cur;
    bit         in_frame = 1'b0;
    int         pos = 0;
    int         s, c;
    logic [3:0] exp_an;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame = 1'b0;
            pos = 0;
        end else begin
            if (frame_start) begin
                if (in_frame) chk("frame_period", pos, FRM);
                if (sb.size() > 0) begin
                    cur = sb.pop_front();
                    in_frame = 1'b1;
                end else begin
                    in_frame = 1'b0;
                end
                pos = 0;
            end
            if (in_frame) begin
                if (pos == FRM) begin
                    chk("frame_start_missing", frame_start, 1);
                    in_frame = 1'b0;
                end else begin
                    s = pos / DIV;
                    c = pos % DIV;
                    exp_an = (c < DIV - DEAD && !cur.blank[s])
                           ? ~(4'b0001 << s) : 4'hF;
                    chk("anode_n", anode_n, exp_an);
                    chk("digit_out", digit_out, cur.digits[4*s +: 4]);
                    chk("digit_blank", digit_blank, cur.blank[s]);
                    pos++;
                end
            end
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic go_to(int t);
        tick(t - cyc);
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_anode"}, anode_n, 4'hF);
        chk({tag, "_digit"}, digit_out, 0);
        chk({tag, "_blank"}, digit_blank, 0);
        chk({tag, "_fs"}, frame_start, 0);
        chk({tag, "_ready"}, lif.load_ready, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        lif.load_valid = 1'b0;
        lif.load_data  = '0;
        blank_lz       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("rst");

        sb.push_back(mk(16'h0000, 4'b0000));
        sb.push_back(mk(16'h4321, 4'b0000));
        sb.push_back(mk(16'h0050, 4'b1100));
        sb.push_back(mk(16'h0000, 4'b1110));
        sb.push_back(mk(16'h0000, 4'b1110));
        sb.push_back(mk(16'hAAAA, 4'b0000));
        sb.push_back(mk(16'hBBBB, 4'b0000));

        rst_n = 1'b1;
        cyc = 0;
        go_to(1);
        chk("first_frame_start", frame_start, 1);

        go_to(5);
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h4321;
        go_to(6);
        chk("ready_low_after_accept", lif.load_ready, 0);
        lif.load_valid = 1'b0;

        go_to(32);
        chk("old_data_until_boundary", digit_out, 0);
        go_to(33);
        chk("ready_high_at_commit", lif.load_ready, 1);
        chk("new_digit0_at_fs", digit_out, 1);

        go_to(40);
        blank_lz = 1'b1;
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h0050;
        go_to(41);
        lif.load_valid = 1'b0;

        go_to(70);
        lif.load_valid = 1'b1;
        lif.load_data  = 16'h0000;
        go_to(71);
        lif.load_valid = 1'b0;

        go_to(127);
        lif.load_valid = 1'b1;
        lif.load_data  = 16'hAAAA;
        go_to(128);
        chk("accept_on_commit_cycle", lif.load_ready, 0);
        lif.load_data  = 16'hBBBB;
        go_to(160);
        chk("ready_after_aaaa_commit", lif.load_ready, 1);
        go_to(161);
        chk("bbbb_accepted_next", lif.load_ready, 0);
        lif.load_valid = 1'b0;

        go_to(195);
        blank_lz = 1'b0;
        go_to(200);
        lif.load_valid = 1'b1;
        lif.load_data  = 16'hCCCC;
        go_to(201);
        chk("cccc_pending", lif.load_ready, 0);
        lif.load_valid = 1'b0;

        go_to(210);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        chk("sb_drained_pre_reset", sb.size(), 0);

        repeat (2) @(posedge clk);
        #1;
        sb.push_back(mk(16'h0000, 4'b0000));
        sb.push_back(mk(16'h0000, 4'b0000));
        rst_n = 1'b1;
        cyc = 0;
        go_to(1);
        chk("post_reset_fs", frame_start, 1);
        chk("post_reset_ready", lif.load_ready, 1);
        go_to(2 * FRM + 2);
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
